arm_exec_unit: RTL and testbench

ARM_EXEC_UNIT -- requirements
Module: arm_exec_unit

---
 rtl/arm_pkg.sv | 38 +++
 rtl/arm_shift_unit.sv | 69 ++++++
 rtl/arm_exec_unit.sv | 165 ++++++++++++++++
 tb/tb_arm_exec_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared encodings for the ARM execute slice: ALU opcodes, shift types,
// CPSR flag positions and the default halt instruction.
package arm_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3
  } shift_type_e;

  localparam int CPSR_N = 31;
  localparam int CPSR_Z = 30;
  localparam int CPSR_C = 29;
  localparam int CPSR_V = 28;

  localparam logic [31:0] HALT_INST_DEFAULT = 32'hE3A000BB;
  localparam logic [3:0]  REG_PC = 4'd15;
  localparam logic [3:0]  REG_LR = 4'd14;

  // Compare/test opcodes only touch the flags, never Rd.
  function automatic logic is_test_op(input alu_op_e op);
    return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

  function automatic logic is_arith_op(input alu_op_e op);
    case (op)
      OP_SUB, OP_RSB, OP_ADD, OP_ADC,
      OP_SBC, OP_RSC, OP_CMP, OP_CMN: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm_shift_unit.sv
// Barrel shifter for the data-processing second operand: rotated immediate,
// immediate-amount shifts (with the #0 special cases) and register shifts.
module arm_shift_unit
  import arm_pkg::*;
(
  input  logic        i_imm,
  input  logic        i_reg_shift,
  input  logic [11:0] i_operand2,
  input  logic [31:0] i_rm,
  input  logic [7:0]  i_rs,
  input  logic        i_carry,
  output logic [31:0] o_op,
  output logic        o_carry
);

  shift_type_e w_type;
  logic [4:0]  w_rot;
  logic [7:0]  w_amt;
  logic [5:0]  w_asr_amt;
  logic [4:0]  w_ror_n;
  logic [31:0] w_imm32;
  logic [31:0] w_imm_ror;
  logic [31:0] w_ror;
  logic [32:0] w_lsl;
  logic [32:0] w_lsr;
  logic [32:0] w_asr;
  logic        w_imm_zero;

  assign w_type     = shift_type_e'(i_operand2[6:5]);
  assign w_rot      = {i_operand2[11:8], 1'b0};
  assign w_imm_zero = (i_operand2[11:7] == 5'd0);

  // Immediate LSR/ASR #0 encode a shift by 32.
  always_comb begin
    w_amt = i_reg_shift ? i_rs : {3'b000, i_operand2[11:7]};
    if (!i_reg_shift && w_imm_zero && ((w_type == SH_LSR) || (w_type == SH_ASR)))
      w_amt = 8'd32;
  end

  // One extra bit below/above the word catches the last bit shifted out.
  assign w_lsl     = {1'b0, i_rm} << w_amt;
  assign w_lsr     = {i_rm, 1'b0} >> w_amt;
  assign w_asr_amt = (w_amt >= 8'd32) ? 6'd32 : w_amt[5:0];
  assign w_asr     = $signed({i_rm, 1'b0}) >>> w_asr_amt;
  assign w_ror_n   = w_amt[4:0];
  assign w_ror     = (i_rm >> w_ror_n) | (i_rm << (6'd32 - {1'b0, w_ror_n}));
  assign w_imm32   = {24'b0, i_operand2[7:0]};
  assign w_imm_ror = (w_imm32 >> w_rot) | (w_imm32 << (6'd32 - {1'b0, w_rot}));

  always_comb begin
    o_op    = i_rm;
    o_carry = i_carry;
    if (i_imm) begin
      o_op    = w_imm_ror;
      o_carry = (w_rot == 5'd0) ? i_carry : w_imm_ror[31];
    end else if (!i_reg_shift && w_imm_zero && (w_type == SH_ROR)) begin
      o_op    = {i_carry, i_rm[31:1]};
      o_carry = i_rm[0];
    end else if (w_amt != 8'd0) begin
      case (w_type)
        SH_LSL: begin o_op = w_lsl[31:0];  o_carry = w_lsl[32]; end
        SH_LSR: begin o_op = w_lsr[32:1];  o_carry = w_lsr[0];  end
        SH_ASR: begin o_op = w_asr[32:1];  o_carry = w_asr[0];  end
        default: begin o_op = w_ror;       o_carry = w_ror[31]; end
      endcase
    end
  end

endmodule

// File: rtl/arm_exec_unit.sv
// Single-cycle ARM execute stage: decodes data-processing and branch
// instructions, runs the ALU and registers the resulting write-backs.
module arm_exec_unit
  import arm_pkg::*;
#(
  parameter logic [31:0] HALT_INST = HALT_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        cond_pass,
  input  logic [31:0] rn_val,
  input  logic [31:0] rm_val,
  input  logic [31:0] rs_val,
  input  logic [31:0] pc,
  input  logic [31:0] cpsr,
  output logic [3:0]  read_rn,
  output logic [3:0]  read_rm,
  output logic [3:0]  read_rs,
  output logic        rd_we,
  output logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        pc_we,
  output logic [31:0] pc_next,
  output logic        cpsr_we,
  output logic [31:0] cpsr_next,
  output logic        halted
);

  logic        r_rd_we, r_pc_we, r_cpsr_we, r_halted;
  logic [3:0]  r_rd_addr;
  logic [31:0] r_rd_data, r_pc_next, r_cpsr_next;

  logic [31:0] w_pc4, w_pc8, w_rn_op, w_rm_op, w_sh_op, w_logic, w_result;
  logic [31:0] w_add_a, w_add_b, w_br_target;
  logic [32:0] w_sum;
  logic        w_add_cin, w_sh_carry, w_arith, w_c, w_v;
  logic        w_is_mul, w_is_dp, w_is_br, w_test, w_flag_upd;
  logic        w_rd_we_n, w_cpsr_we_n;
  logic [3:0]  w_rd_addr_n;
  logic [31:0] w_rd_data_n, w_pc_next_n, w_cpsr_next_n;
  logic        w_unused_rs;
  alu_op_e     w_op;

  assign read_rn     = inst[19:16];
  assign read_rm     = inst[3:0];
  assign read_rs     = inst[11:8];
  assign w_unused_rs = ^rs_val[31:8];

  assign w_pc4   = pc + 32'd4;
  assign w_pc8   = pc + 32'd8;
  assign w_rn_op = (inst[19:16] == REG_PC) ? w_pc8 : rn_val;
  assign w_rm_op = (inst[3:0] == REG_PC) ? w_pc8 : rm_val;

  assign w_is_mul    = (inst[27:22] == 6'b000000) && (inst[7:4] == 4'b1001);
  assign w_is_dp     = (inst[27:26] == 2'b00) && !(!inst[25] && inst[7] && inst[4]);
  assign w_is_br     = (inst[27:25] == 3'b101);
  assign w_op        = alu_op_e'(inst[24:21]);
  assign w_test      = is_test_op(w_op);
  assign w_arith     = is_arith_op(w_op);
  assign w_flag_upd  = inst[20] || w_test;
  assign w_br_target = w_pc8 + {{6{inst[23]}}, inst[23:0], 2'b00};

  arm_shift_unit u_shift (
    .i_imm       (inst[25]),
    .i_reg_shift (inst[4]),
    .i_operand2  (inst[11:0]),
    .i_rm        (w_rm_op),
    .i_rs        (rs_val[7:0]),
    .i_carry     (cpsr[CPSR_C]),
    .o_op        (w_sh_op),
    .o_carry     (w_sh_carry)
  );

  // Subtracts are a + ~b + carry so the adder carry-out is NOT borrow.
  always_comb begin
    w_add_a   = w_rn_op;
    w_add_b   = w_sh_op;
    w_add_cin = 1'b0;
    w_logic   = 32'd0;
    case (w_op)
      OP_AND, OP_TST: w_logic = w_rn_op & w_sh_op;
      OP_EOR, OP_TEQ: w_logic = w_rn_op ^ w_sh_op;
      OP_ORR:         w_logic = w_rn_op | w_sh_op;
      OP_MOV:         w_logic = w_sh_op;
      OP_BIC:         w_logic = w_rn_op & ~w_sh_op;
      OP_MVN:         w_logic = ~w_sh_op;
      OP_SUB, OP_CMP: begin w_add_b = ~w_sh_op; w_add_cin = 1'b1; end
      OP_RSB:         begin w_add_a = w_sh_op; w_add_b = ~w_rn_op; w_add_cin = 1'b1; end
      OP_ADC:         w_add_cin = cpsr[CPSR_C];
      OP_SBC:         begin w_add_b = ~w_sh_op; w_add_cin = cpsr[CPSR_C]; end
      OP_RSC:         begin w_add_a = w_sh_op; w_add_b = ~w_rn_op; w_add_cin = cpsr[CPSR_C]; end
      default:        ;
    endcase
  end

  assign w_sum    = {1'b0, w_add_a} + {1'b0, w_add_b} + {32'd0, w_add_cin};
  assign w_result = w_arith ? w_sum[31:0] : w_logic;
  assign w_c      = w_arith ? w_sum[32] : w_sh_carry;
  assign w_v      = w_arith ? ((w_add_a[31] == w_add_b[31]) && (w_sum[31] != w_add_a[31]))
                            : cpsr[CPSR_V];

  always_comb begin
    w_rd_we_n      = 1'b0;
    w_rd_addr_n    = inst[15:12];
    w_rd_data_n    = w_result;
    w_pc_next_n    = w_pc4;
    w_cpsr_we_n    = 1'b0;
    w_cpsr_next_n  = cpsr;
    if (cond_pass && w_is_dp && !w_is_mul) begin
      if (!w_test) begin
        if (inst[15:12] == REG_PC) w_pc_next_n = w_result;
        else                       w_rd_we_n   = 1'b1;
      end
      if (w_flag_upd) begin
        w_cpsr_we_n   = 1'b1;
        w_cpsr_next_n = {w_result[31], (w_result == 32'd0), w_c, w_v, cpsr[27:0]};
      end
    end else if (cond_pass && w_is_br) begin
      w_pc_next_n = w_br_target;
      if (inst[24]) begin
        w_rd_we_n   = 1'b1;
        w_rd_addr_n = REG_LR;
        w_rd_data_n = w_pc4;
      end
    end
  end

  // Once halted only the enables are forced low; data outputs hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_we     <= 1'b0;
      r_rd_addr   <= 4'd0;
      r_rd_data   <= 32'd0;
      r_pc_we     <= 1'b0;
      r_pc_next   <= 32'd0;
      r_cpsr_we   <= 1'b0;
      r_cpsr_next <= 32'd0;
      r_halted    <= 1'b0;
    end else if (r_halted) begin
      r_rd_we   <= 1'b0;
      r_pc_we   <= 1'b0;
      r_cpsr_we <= 1'b0;
    end else begin
      r_rd_we     <= w_rd_we_n;
      r_rd_addr   <= w_rd_addr_n;
      r_rd_data   <= w_rd_data_n;
      r_pc_we     <= 1'b1;
      r_pc_next   <= w_pc_next_n;
      r_cpsr_we   <= w_cpsr_we_n;
      r_cpsr_next <= w_cpsr_next_n;
      r_halted    <= (inst == HALT_INST);
    end
  end

  assign rd_we     = r_rd_we;
  assign rd_addr   = r_rd_addr;
  assign rd_data   = r_rd_data;
  assign pc_we     = r_pc_we;
  assign pc_next   = r_pc_next;
  assign cpsr_we   = r_cpsr_we;
  assign cpsr_next = r_cpsr_next;
  assign halted    = r_halted;

endmodule

// File: tb/tb_arm_exec_unit.sv
// Randomized and directed checks of arm_exec_unit against an arithmetic
// reference model of the instruction semantics.
module tb_arm_exec_unit;

  localparam logic [31:0] HALT = 32'hE3A000BB;

  typedef struct packed {
    logic        halted;
    logic        rd_we;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic        pc_we;
    logic [31:0] pc_next;
    logic        cpsr_we;
    logic [31:0] cpsr_next;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst = 32'd0;
  logic        cond_pass = 1'b0;
  logic [31:0] rn_val = 32'd0, rm_val = 32'd0, rs_val = 32'd0, pc = 32'd0, cpsr = 32'd0;
  logic [3:0]  read_rn, read_rm, read_rs;
  logic        rd_we, pc_we, cpsr_we, halted;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data, pc_next, cpsr_next;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic m_halted = 1'b0;
  exp_t exp_q[$];

  // ---------------- clock / DUT ----------------
  always #5 clk = ~clk;

  arm_exec_unit dut (
    .clk(clk), .rst(rst), .inst(inst), .cond_pass(cond_pass),
    .rn_val(rn_val), .rm_val(rm_val), .rs_val(rs_val), .pc(pc), .cpsr(cpsr),
    .read_rn(read_rn), .read_rm(read_rm), .read_rs(read_rs),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .pc_we(pc_we), .pc_next(pc_next), .cpsr_we(cpsr_we), .cpsr_next(cpsr_next),
    .halted(halted)
  );

  // ---------------- checker ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void ref_shift(input logic [31:0] i, input logic [31:0] rm,
                                    input logic [31:0] rs, input logic c,
                                    output logic [31:0] op, output logic co);
    int n, k;
    logic [1:0]  t;
    logic [31:0] v;
    t  = i[6:5];
    op = rm;
    co = c;
    if (i[25]) begin
      k = 2 * int'(i[11:8]);
      v = {24'd0, i[7:0]};
      for (int j = 0; j < 32; j++) op[j] = v[(j + k) % 32];
      co = (k == 0) ? c : op[31];
      return;
    end
    if (i[4]) n = int'(rs[7:0]);
    else begin
      n = int'(i[11:7]);
      if (n == 0 && t == 2'b11) begin
        op = {c, rm[31:1]};
        co = rm[0];
        return;
      end
      if (n == 0 && t != 2'b00) n = 32;
    end
    if (n == 0) return;
    case (t)
      2'b00: begin
        if (n < 32)       begin op = rm << n; co = rm[32 - n]; end
        else if (n == 32) begin op = 32'd0;   co = rm[0];      end
        else              begin op = 32'd0;   co = 1'b0;       end
      end
      2'b01: begin
        if (n < 32)       begin op = rm >> n; co = rm[n - 1];  end
        else if (n == 32) begin op = 32'd0;   co = rm[31];     end
        else              begin op = 32'd0;   co = 1'b0;       end
      end
      2'b10: begin
        if (n < 32) begin op = $signed(rm) >>> n; co = rm[n - 1]; end
        else        begin op = {32{rm[31]}};      co = rm[31];    end
      end
      default: begin
        k = n % 32;
        if (k == 0) co = rm[31];
        else begin
          for (int j = 0; j < 32; j++) op[j] = rm[(j + k) % 32];
          co = rm[k - 1];
        end
      end
    endcase
  endfunction

  function automatic exp_t ref_model(input logic [31:0] i, input logic cp,
                                     input logic [31:0] rn, input logic [31:0] rm,
                                     input logic [31:0] rs, input logic [31:0] p,
                                     input logic [31:0] ps);
    exp_t        e;
    logic [31:0] a, rmx, b, res;
    logic        sc, cf, vf, arith, is_mul, is_dp, test;
    logic [3:0]  op;
    longint      ua, ub, ur, sa, sb, sr, cin, bor;
    e           = '0;
    e.pc_we     = 1'b1;
    e.pc_next   = p + 32'd4;
    e.cpsr_next = ps;
    if (!cp) return e;
    if (i[27:25] == 3'b101) begin
      e.pc_next = 32'(longint'(p) + 8 + 4 * longint'($signed(i[23:0])));
      if (i[24]) begin
        e.rd_we   = 1'b1;
        e.rd_addr = 4'd14;
        e.rd_data = p + 32'd4;
      end
      return e;
    end
    is_mul = (i[27:22] == 6'd0) && (i[7:4] == 4'b1001);
    is_dp  = (i[27:26] == 2'b00) && !is_mul;
    if (!is_dp) return e;
    a   = (i[19:16] == 4'd15) ? p + 32'd8 : rn;
    rmx = (i[3:0] == 4'd15) ? p + 32'd8 : rm;
    ref_shift(i, rmx, rs, ps[29], b, sc);
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    cin = ps[29] ? 1 : 0;
    bor = 1 - cin;
    op = i[24:21];
    arith = 1'b1;
    cf = sc;
    vf = ps[28];
    ur = 0;
    sr = 0;
    res = 32'd0;
    case (op)
      4'h0, 4'h8: begin res = a & b;  arith = 1'b0; end
      4'h1, 4'h9: begin res = a ^ b;  arith = 1'b0; end
      4'hC:       begin res = a | b;  arith = 1'b0; end
      4'hD:       begin res = b;      arith = 1'b0; end
      4'hE:       begin res = a & ~b; arith = 1'b0; end
      4'hF:       begin res = ~b;     arith = 1'b0; end
      4'h2, 4'hA: begin ur = ua - ub; sr = sa - sb; cf = (ua >= ub); end
      4'h3:       begin ur = ub - ua; sr = sb - sa; cf = (ub >= ua); end
      4'h4, 4'hB: begin ur = ua + ub; sr = sa + sb; cf = (ur >= 64'h1_0000_0000); end
      4'h5:       begin ur = ua + ub + cin; sr = sa + sb + cin; cf = (ur >= 64'h1_0000_0000); end
      4'h6:       begin ur = ua - ub - bor; sr = sa - sb - bor; cf = (ua >= ub + bor); end
      default:    begin ur = ub - ua - bor; sr = sb - sa - bor; cf = (ub >= ua + bor); end
    endcase
    if (arith) begin
      res = 32'(ur);
      vf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    end
    test = (op >= 4'h8) && (op <= 4'hB);
    if (!test) begin
      if (i[15:12] == 4'd15) e.pc_next = res;
      else begin
        e.rd_we   = 1'b1;
        e.rd_addr = i[15:12];
        e.rd_data = res;
      end
    end
    if (test || i[20]) begin
      e.cpsr_we   = 1'b1;
      e.cpsr_next = {res[31], (res == 32'd0), cf, vf, ps[27:0]};
    end
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic score();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val("queue_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check_val("halted", {31'd0, halted}, {31'd0, e.halted});
    check_val("rd_we", {31'd0, rd_we}, {31'd0, e.rd_we});
    check_val("pc_we", {31'd0, pc_we}, {31'd0, e.pc_we});
    check_val("cpsr_we", {31'd0, cpsr_we}, {31'd0, e.cpsr_we});
    if (e.rd_we) begin
      check_val("rd_addr", {28'd0, rd_addr}, {28'd0, e.rd_addr});
      check_val("rd_data", rd_data, e.rd_data);
    end
    if (e.pc_we)   check_val("pc_next", pc_next, e.pc_next);
    if (e.cpsr_we) check_val("cpsr_next", cpsr_next, e.cpsr_next);
  endtask

  // ---------------- drivers ----------------
  task automatic apply(input logic [31:0] i, input logic cp, input logic [31:0] rn,
                       input logic [31:0] rm, input logic [31:0] rs,
                       input logic [31:0] p, input logic [31:0] ps);
    exp_t e;
    inst = i; cond_pass = cp; rn_val = rn; rm_val = rm; rs_val = rs; pc = p; cpsr = ps;
    #1;
    check_val("read_rn", {28'd0, read_rn}, {28'd0, i[19:16]});
    check_val("read_rm", {28'd0, read_rm}, {28'd0, i[3:0]});
    check_val("read_rs", {28'd0, read_rs}, {28'd0, i[11:8]});
    e = ref_model(i, cp, rn, rm, rs, p, ps);
    if (m_halted) begin
      e.rd_we = 1'b0; e.pc_we = 1'b0; e.cpsr_we = 1'b0;
    end
    e.halted = m_halted || (i == HALT);
    m_halted = e.halted;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    score();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [31:0] i);
    rst = 1'b0; inst = i; cond_pass = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_rd_we", {31'd0, rd_we}, 32'd0);
    check_val("rst_pc_we", {31'd0, pc_we}, 32'd0);
    check_val("rst_cpsr_we", {31'd0, cpsr_we}, 32'd0);
    check_val("rst_halted", {31'd0, halted}, 32'd0);
    check_val("rst_rd_addr", {28'd0, rd_addr}, 32'd0);
    check_val("rst_rd_data", rd_data, 32'd0);
    check_val("rst_pc_next", pc_next, 32'd0);
    check_val("rst_cpsr_next", cpsr_next, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    m_halted = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic random_op();
    logic [31:0] i, rs;
    logic [2:0]  top;
    i  = $urandom;
    rs = $urandom;
    case ($urandom_range(0, 3))
      0: rs[7:0] = 8'($urandom_range(0, 31));
      1: rs[7:0] = 8'($urandom_range(32, 33));
      2: rs[7:0] = 8'd0;
      default: ;
    endcase
    case ($urandom_range(0, 9))
      0, 1, 2: i[27:25] = 3'b001;
      3, 4:    begin i[27:25] = 3'b000; i[4] = 1'b0; end
      5, 6:    begin i[27:25] = 3'b000; i[7] = 1'b0; i[4] = 1'b1; end
      7:       i[27:25] = 3'b101;
      8:       begin i[27:22] = 6'd0; i[7:4] = 4'b1001; end
      default: begin
        case ($urandom_range(0, 4))
          0: top = 3'b010;
          1: top = 3'b011;
          2: top = 3'b100;
          3: top = 3'b110;
          default: top = 3'b111;
        endcase
        i[27:25] = top;
      end
    endcase
    if (i == HALT) i[0] = ~i[0];
    apply(i, ($urandom_range(0, 7) != 0), pick_val(), pick_val(), rs,
          $urandom & 32'hFFFF_FFFC, $urandom);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    @(negedge clk);
    do_reset(32'd0);

    // ADDS r0, r1, r2 with carry-out into zero
    apply(32'hE0910002, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h200, 32'h0);
    check_val("adds_data", rd_data, 32'h0);
    check_val("adds_addr", {28'd0, rd_addr}, 32'd0);
    check_val("adds_nzcv", {28'd0, cpsr_next[31:28]}, 32'h6);

    // MOV r3, #0xFF000000 and its S form
    apply(32'hE3A034FF, 1'b1, 32'h0, 32'h0, 32'h0, 32'h300, 32'h0);
    check_val("mov_imm_data", rd_data, 32'hFF00_0000);
    apply(32'hE3B034FF, 1'b1, 32'h0, 32'h0, 32'h0, 32'h304, 32'h0);
    check_val("movs_imm_c", {31'd0, cpsr_next[29]}, 32'd1);

    // MOVS r4, r5, LSR r6 by 32 and 33
    apply(32'hE1B04635, 1'b1, 32'h0, 32'h8000_0000, 32'd32, 32'h400, 32'h0);
    check_val("lsr32_data", rd_data, 32'h0);
    check_val("lsr32_zc", {30'd0, cpsr_next[30:29]}, 32'd3);
    apply(32'hE1B04635, 1'b1, 32'h0, 32'h8000_0000, 32'd33, 32'h404, 32'h2000_0000);
    check_val("lsr33_c", {31'd0, cpsr_next[29]}, 32'd0);

    // CMP r1, r1 passing and failing the condition
    apply(32'hE1510001, 1'b1, 32'h1234, 32'h1234, 32'h0, 32'h500, 32'h0);
    check_val("cmp_rd_we", {31'd0, rd_we}, 32'd0);
    check_val("cmp_zc", {30'd0, cpsr_next[30:29]}, 32'd3);
    apply(32'hE1510001, 1'b0, 32'h1234, 32'h1234, 32'h0, 32'h600, 32'h0);
    check_val("cmp_nc_cpsr_we", {31'd0, cpsr_we}, 32'd0);
    check_val("cmp_nc_pc", pc_next, 32'h604);

    // BL to itself at pc=100
    apply(32'hEBFFFFFE, 1'b1, 32'h0, 32'h0, 32'h0, 32'd100, 32'h0);
    check_val("bl_pc", pc_next, 32'd100);
    check_val("bl_lr", rd_data, 32'd104);

    // MOV pc, r2 redirects the PC instead of writing a register
    apply(32'hE1A0F002, 1'b1, 32'h0, 32'h0000_4000, 32'h0, 32'h700, 32'h0);
    check_val("mov_pc_target", pc_next, 32'h0000_4000);

    for (int n = 0; n < 400; n++) random_op();

    // Halt: executes the MOV, then suppresses all writes until reset
    apply(HALT, 1'b1, 32'h0, 32'h0, 32'h0, 32'h800, 32'h0);
    check_val("halt_flag", {31'd0, halted}, 32'd1);
    check_val("halt_mov_data", rd_data, 32'hBB);
    apply(32'hE0910002, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h804, 32'h0);
    check_val("halt_wes", {29'd0, rd_we, pc_we, cpsr_we}, 32'd0);
    for (int n = 0; n < 20; n++) random_op();
    do_reset(HALT);
    apply(32'hE0910002, 1'b1, 32'h5, 32'h6, 32'h0, 32'h900, 32'h0);
    check_val("post_reset_data", rd_data, 32'hB);
    for (int n = 0; n < 100; n++) random_op();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
